// File: rtl/hdmi_timing_if.sv
// hdmi_timing_if: video timing bundle between the timing generator and its consumers.
// master = generator (enable in; running/frame_start/fetch/x/y/active/h_sync/v_sync out).
// Macro HDMI_TIMING_FRAME_COUNT_EN adds frame_count.
interface hdmi_timing_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          enable;
  logic          running;
  logic          frame_start;
  logic          fetch;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active;
  logic          h_sync;
  logic          v_sync;
`ifdef HDMI_TIMING_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  modport master (
    input  enable,
    output running,
    output frame_start,
    output fetch,
    output x,
    output y,
    output active,
    output h_sync,
    output v_sync
`ifdef HDMI_TIMING_FRAME_COUNT_EN
    , output frame_count
`endif
  );

  modport slave (
    output enable,
    input  running,
    input  frame_start,
    input  fetch,
    input  x,
    input  y,
    input  active,
    input  h_sync,
    input  v_sync
`ifdef HDMI_TIMING_FRAME_COUNT_EN
    , input frame_count
`endif
  );
endinterface

// File: rtl/hdmi_timing.sv
// hdmi_timing: video timing generator and pixel-fetch sequencer.
// Purpose: issues fetch/x/y early, then active/h_sync/v_sync LEAD cycles later
//   for the TMDS encoder; starts and stops only on frame boundaries.
// Ports:
//   i_clk   pixel clock
//   i_reset asynchronous, active-high reset
//   io_vid  hdmi_timing_if.master (enable in; timing outputs out)
// Option: define HDMI_TIMING_FRAME_COUNT_EN to add a 16-bit frame_count.
module hdmi_timing #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int SYNC_POSITIVE = 0,
  parameter int LEAD          = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  hdmi_timing_if.master io_vid
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  localparam logic [XW-1:0] X_LAST =
    XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT =
    XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS_BEG =
    XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] X_HS_END =
    XW'(H_ACTIVE + H_FRONT + H_SYNC);

  localparam logic [YW-1:0] Y_LAST =
    YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT =
    YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS_BEG =
    YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] Y_VS_END =
    YW'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [XW-1:0] r_h;
  logic [XW-1:0] w_h_nx;
  logic [YW-1:0] r_v;
  logic [YW-1:0] w_v_nx;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_run_nx;
  logic          w_fetch_nx;
  logic          w_fs_nx;
  logic          w_hs0_nx;
  logic          w_vs0_nx;

  logic          r_running;
  logic          r_frame_start;
  logic          r_fetch;
  logic          r_hs0;
  logic          r_vs0;

  logic          w_act_d;
  logic          w_hs_d;
  logic          w_vs_d;

  assign w_h_last = (r_h == X_LAST);
  assign w_v_last = (r_v == Y_LAST);

  // Next raster position. enable is only looked at in IDLE
  // and on the final pixel of a frame, so frames never truncate.
  always_comb begin
    w_state_nx = r_state;
    w_h_nx     = r_h;
    w_v_nx     = r_v;
    unique case (r_state)
      S_IDLE: begin
        w_h_nx = '0;
        w_v_nx = '0;
        if (io_vid.enable) begin
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_h_last) begin
          w_h_nx = r_h + 1'b1;
        end else begin
          w_h_nx = '0;
          if (!w_v_last) begin
            w_v_nx = r_v + 1'b1;
          end else begin
            w_v_nx = '0;
            if (!io_vid.enable) begin
              w_state_nx = S_IDLE;
            end
          end
        end
      end
    endcase
  end

  // Fetch-stage decode of the upcoming position, so the
  // registered flags line up with the counters they describe.
  assign w_run_nx = (w_state_nx == S_RUN);

  assign w_fetch_nx = w_run_nx
                    && (w_h_nx < X_ACT)
                    && (w_v_nx < Y_ACT);

  assign w_fs_nx = w_run_nx
                 && (w_h_nx == '0)
                 && (w_v_nx == '0);

  assign w_hs0_nx = w_run_nx
                  && (w_h_nx >= X_HS_BEG)
                  && (w_h_nx < X_HS_END);

  // v only changes at h=0, so this spans whole lines.
  assign w_vs0_nx = w_run_nx
                  && (w_v_nx >= Y_VS_BEG)
                  && (w_v_nx < Y_VS_END);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_h           <= '0;
      r_v           <= '0;
      r_running     <= 1'b0;
      r_frame_start <= 1'b0;
      r_fetch       <= 1'b0;
      r_hs0         <= 1'b0;
      r_vs0         <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_h           <= w_h_nx;
      r_v           <= w_v_nx;
      r_running     <= w_run_nx;
      r_frame_start <= w_fs_nx;
      r_fetch       <= w_fetch_nx;
      r_hs0         <= w_hs0_nx;
      r_vs0         <= w_vs0_nx;
    end
  end

  // Delay line carries active-high flags; polarity is
  // applied only at the output, so 0 is always "inactive".
  generate
    if (LEAD == 0) begin : g_nodly
      assign w_act_d = r_fetch;
      assign w_hs_d  = r_hs0;
      assign w_vs_d  = r_vs0;
    end else begin : g_dly
      logic [2:0] r_dly [LEAD];

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          for (int i = 0; i < LEAD; i++) begin
            r_dly[i] <= 3'b000;
          end
        end else begin
          r_dly[0] <= {r_fetch, r_hs0, r_vs0};
          for (int i = 1; i < LEAD; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_act_d = r_dly[LEAD-1][2];
      assign w_hs_d  = r_dly[LEAD-1][1];
      assign w_vs_d  = r_dly[LEAD-1][0];
    end
  endgenerate

  assign io_vid.running     = r_running;
  assign io_vid.frame_start = r_frame_start;
  assign io_vid.fetch       = r_fetch;
  assign io_vid.x           = r_h;
  assign io_vid.y           = r_v;
  assign io_vid.active      = w_act_d;
  assign io_vid.h_sync      =
    (SYNC_POSITIVE != 0) ? w_hs_d : ~w_hs_d;
  assign io_vid.v_sync      =
    (SYNC_POSITIVE != 0) ? w_vs_d : ~w_vs_d;

`ifdef HDMI_TIMING_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Bumps the cycle after each frame_start pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame_count <= '0;
    end else if (r_frame_start) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign io_vid.frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_hdmi_timing.sv
// tb_hdmi_timing: scoreboard bench for hdmi_timing on an 8x6 raster, LEAD=2.
// Expected outputs come from a frame-position model pushed at drive time.
module tb_hdmi_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hdmi_timing_if #(.XW(3), .YW(3)) vid ();

  hdmi_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POSITIVE(0), .LEAD(2)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_vid (vid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic        fs;
    logic        fetch;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        act;
    logic        hs;
    logic        vs;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ob_fs = 0;
  int   ob_fetch = 0;

  // Model: frame position 0..47 (pos = v*8 + h)
  logic        m_run;
  int          m_pos;
  logic        m_fetch, m_hs, m_vs, m_fs;
  logic [2:0]  m_x, m_y;
  logic [2:0]  m_d1, m_d2;
  logic [15:0] m_fc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, want, $time);
    end
  endtask

  task automatic m_derive();
    int h, v;
    h = m_pos % 8;
    v = m_pos / 8;
    if (m_run) begin
      m_fetch = (h < 4) && (v < 3);
      m_hs    = (h == 5) || (h == 6);
      m_vs    = (v == 4);
      m_fs    = (m_pos == 0);
      m_x     = 3'(h);
      m_y     = 3'(v);
    end else begin
      m_fetch = 0; m_hs = 0; m_vs = 0; m_fs = 0;
      m_x = 0; m_y = 0;
    end
  endtask

  task automatic m_reset();
    m_run = 0;
    m_pos = 0;
    m_d1  = 0;
    m_d2  = 0;
    m_fc  = 0;
    m_derive();
  endtask

  task automatic m_edge(input logic en);
    m_d2 = m_d1;
    m_d1 = {m_fetch, m_hs, m_vs};
    if (m_fs) m_fc = m_fc + 16'd1;
    if (!m_run) begin
      if (en) begin
        m_run = 1;
        m_pos = 0;
      end
    end else if (m_pos == 47) begin
      m_pos = 0;
      if (!en) m_run = 0;
    end else begin
      m_pos = m_pos + 1;
    end
    m_derive();
  endtask

  function automatic exp_t m_exp();
    exp_t e;
    e.run   = m_run;
    e.fs    = m_fs;
    e.fetch = m_fetch;
    e.x     = m_x;
    e.y     = m_y;
    e.act   = m_d2[2];
    e.hs    = ~m_d2[1];
    e.vs    = ~m_d2[0];
    e.fc    = m_fc;
    return e;
  endfunction

  task automatic cmp_out(input exp_t e);
    chk("running", 32'(vid.running), 32'(e.run));
    chk("fstart",  32'(vid.frame_start), 32'(e.fs));
    chk("fetch",   32'(vid.fetch), 32'(e.fetch));
    chk("x",       32'(vid.x), 32'(e.x));
    chk("y",       32'(vid.y), 32'(e.y));
    chk("active",  32'(vid.active), 32'(e.act));
    chk("hsync",   32'(vid.h_sync), 32'(e.hs));
    chk("vsync",   32'(vid.v_sync), 32'(e.vs));
`ifdef HDMI_TIMING_FRAME_COUNT_EN
    chk("fcount",  32'(vid.frame_count), 32'(e.fc));
`endif
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      cmp_out(e);
    end
    if (vid.frame_start) ob_fs++;
    if (vid.fetch) ob_fetch++;
  endtask

  task automatic cyc(input logic en);
    @(negedge clk);
    vid.enable = en;
    m_edge(en);
    sb_q.push_back(m_exp());
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vid.enable = 1'b0;
    rst = 1'b1;
    m_reset();

    // Held in reset
    repeat (3) begin
      @(negedge clk);
      sb_q.push_back(m_exp());
      @(posedge clk);
      #1;
      pop_cmp();
    end
    @(negedge clk);
    rst = 1'b0;

    // Idle with enable low
    repeat (6) cyc(1'b0);

    // Three free-running frames
    ob_fs = 0;
    ob_fetch = 0;
    repeat (144) cyc(1'b1);
    chk("fs_3frames", 32'(ob_fs), 32'd3);
    chk("fetch_3frames", 32'(ob_fetch), 32'd36);

    // Enter frame 4 to v=1, then drop enable
    repeat (9) cyc(1'b1);
    chk("drop_y", 32'(vid.y), 32'd1);
    ob_fs = 0;
    repeat (45) cyc(1'b0);
    chk("fs_after_drop", 32'(ob_fs), 32'd0);
    chk("idle_after_drop", 32'(vid.running), 32'd0);

    // Restart and reset at h=2, v=1 while active
    repeat (11) cyc(1'b1);
    chk("pre_rst_x", 32'(vid.x), 32'd2);
    chk("pre_rst_act", 32'(vid.active), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_active", 32'(vid.active), 32'd0);
    chk("rst_hsync", 32'(vid.h_sync), 32'd1);
    chk("rst_vsync", 32'(vid.v_sync), 32'd1);
    chk("rst_fetch", 32'(vid.fetch), 32'd0);
    chk("rst_running", 32'(vid.running), 32'd0);
    chk("rst_x", 32'(vid.x), 32'd0);
    m_reset();
    vid.enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // No restart without enable; then a full run and drain
    ob_fs = 0;
    repeat (8) cyc(1'b0);
    chk("no_auto_restart", 32'(ob_fs), 32'd0);
    repeat (60) cyc(1'b1);
    repeat (50) cyc(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_timing.md
# hdmi_timing

Video timing generator and pixel-fetch sequencer that drives the `active`, `h_sync`, `v_sync` inputs of the HDMI TMDS encode path. It also issues an early `fetch` strobe with pixel coordinates so the pixel source can deliver `rgb` aligned with `active`. It sits between the frame-buffer/pixel source and the HDMI encoder in the pixel-clock domain, and starts and stops output only on frame boundaries.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POSITIVE`, 0, 1 = syncs asserted high; 0 = syncs asserted low
- `LEAD`, 2, cycles between `fetch` and `active`; legal range 0..7
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  request video output; level-sensitive
- `running`  out  1  a frame is in progress
- `frame_start`  out  1  one-cycle pulse at h=0, v=0 (fetch stage)
- `fetch`  out  1  pixel request for coordinate (`x`, `y`)
- `x`  out  $clog2(H_TOTAL)  horizontal counter, H_TOTAL = sum of H_*
- `y`  out  $clog2(V_TOTAL)  vertical counter, V_TOTAL = sum of V_*
- `active`  out  1  to encoder; `fetch` delayed LEAD cycles
- `h_sync`  out  1  to encoder; polarity per SYNC_POSITIVE
- `v_sync`  out  1  to encoder; polarity per SYNC_POSITIVE

## Operation
- States: IDLE, RUN.
- IDLE, `enable`=1: next cycle RUN with h=0, v=0 and `frame_start`=1.
- RUN: h increments each cycle and wraps at H_TOTAL-1 to 0. On wrap, v increments and wraps at V_TOTAL-1.
- At the last cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1):
  - `enable`=1: continue to h=0, v=0 with `frame_start`.
  - `enable`=0: go to IDLE.
- Dropping `enable` mid-frame never truncates the frame.
- Fetch-stage signals, registered from the counter state:
  - `fetch` = RUN && h<H_ACTIVE && v<V_ACTIVE.
  - `x`=h, `y`=v.
  - hs0 = RUN && H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC.
  - vs0 = RUN && V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC, for whole lines (transitions at h=0).
- `active`, `h_sync`, `v_sync`:
  - Equal `fetch`, hs0, vs0 passed through a LEAD-deep shift register, with the sync polarity applied.
  - LEAD=0 gives a direct copy.
- In IDLE:
  - Counters hold at 0, and `x`=0, `y`=0.
  - `fetch`, `frame_start`, hs0 and vs0 are inactive.
  - The delay line keeps shifting, so the tail of the last frame drains normally.
- `running` = state is RUN.

## Timing
- Reset values, applied asynchronously:
  - State IDLE; h=0, v=0.
  - `running`, `frame_start`, `fetch`, `active` = 0; `x`, `y` = 0.
  - `h_sync` = `v_sync` = ~SYNC_POSITIVE.
  - Every delay-line stage holds the inactive value.
- Latency:
  - `enable` sampled high in IDLE → `frame_start`/`fetch` on the next cycle.
  - `active` follows `fetch` by exactly LEAD cycles.
- Frame period: H_TOTAL × V_TOTAL cycles. Back-to-back frames have no gap cycle.
- `enable` is sampled only in IDLE and at the last cycle of a frame.
- Reset asserted mid-line: all outputs return to reset values immediately. First frame after release requires `enable`=1.

## Configuration
- `HDMI_TIMING_FRAME_COUNT_EN`:
  - Defined: adds output `frame_count` (16 bits, reset 0). It increments, wrapping, in the cycle after each `frame_start` pulse.
  - Undefined: the port and the counter do not exist.

## Test plan
Small configuration for all tests: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), SYNC_POSITIVE 0, LEAD 2.
- Reset held then released, `enable`=0 → `h_sync`=`v_sync`=1, `active`=`fetch`=`running`=0, `x`=`y`=0 indefinitely.
- `enable` raised at cycle T → `frame_start`=1 and `fetch`=1 at T+1. `x`=0,1,2,3 with `y`=0. `active` high at T+3..T+6.
- Free-running → `h_sync`=0 at h=5,6 of every line (LEAD-delayed), `v_sync`=0 for all of line 4, `frame_start` every 48 cycles, 12 `fetch` per frame.
- `enable` dropped at v=1 → frame completes through h=7, v=5, then `running`=0 and no further `frame_start`. `active`/`h_sync` drain LEAD cycles later.
- Reset pulsed mid-active at h=2, v=1 → `active`=0, `h_sync`=`v_sync`=1 the same cycle, delay line cleared. Restarts only with `enable`.
- With `HDMI_TIMING_FRAME_COUNT_EN`, 3 frames → `frame_count` 0→1→2→3. Without the macro, the bench confirms the port is absent.
